muldiv_iter: RTL

- Multi-cycle integer multiply/divide responder for the CPU datapath.
- Handles the MULT/MULTU/DIV/DIVU class of operations that the single-cycle combinational ALU cannot do.
- Accepts one operation on a valid/ready request channel, iterates one bit per cycle, and returns a HI/LO pair on a valid/ready response channel.
- Sits beside the ALU in the execute stage; the control unit is the initiator.

---
 rtl/muldiv_iter.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative MULT/MULTU/DIV/DIVU unit, one bit per cycle,
// valid/ready request and response channels, registered HI/LO outputs.
// Optional build macro MULDIV_EARLY_EXIT_EN: multiplies stop iterating as soon
// as the remaining multiplier bits are all zero (divide latency unchanged).
module muldiv_iter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_hi,
  output logic [DATA_WIDTH-1:0] resp_lo,
  output logic                  div_by_zero
);

  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned W2 = 2 * DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  // Operation context captured on accept
  logic                 is_div;
  logic                 neg_res;   // product / quotient sign
  logic                 neg_rem;   // remainder sign (dividend sign)
  logic [CNT_WIDTH-1:0] cnt;
  logic [W2-1:0]        acc;       // mul: product accumulator; div: remainder in low half
  logic [W2-1:0]        sh;        // mul: shifted multiplicand; div: divisor in low half
  logic [W-1:0]         mq;        // mul: multiplier shift register; div: dividend/quotient

  // Combinational helpers
  logic          accept;
  logic          dbz;
  logic          a_neg, b_neg;
  logic [W-1:0]  a_mag, b_mag;
  logic [W2-1:0] acc_it, sh_it;
  logic [W-1:0]  mq_it;
  logic [W:0]    rem_sh, dvs_ext;
  logic [W-1:0]  rem_sub;
  logic          ge;
  logic          last;
  logic [W2-1:0] mul_fin;
  logic [W-1:0]  q_fin, r_fin;
  logic [W-1:0]  hi_fin, lo_fin;

  // Request decode: accept qualification, sign extraction and magnitudes
  always_comb begin
    accept = req_valid & req_ready;
    dbz    = accept & req_op[1] & (B == '0);
    a_neg  = ~req_op[0] & A[W-1];
    b_neg  = ~req_op[0] & B[W-1];
    a_mag  = a_neg ? (~A + W'(1)) : A;
    b_mag  = b_neg ? (~B + W'(1)) : B;
  end

  // One iteration of shift-add multiply or restoring divide, plus sign fix-up
  always_comb begin
    rem_sh  = {acc[W-1:0], mq[W-1]};
    dvs_ext = {1'b0, sh[W-1:0]};
    ge      = (rem_sh >= dvs_ext);
    rem_sub = W'(rem_sh - dvs_ext);
    if (is_div) begin
      acc_it = {acc[W2-1:W], (ge ? rem_sub : rem_sh[W-1:0])};
      sh_it  = sh;
      mq_it  = {mq[W-2:0], ge};
    end else begin
      acc_it = mq[0] ? (acc + sh) : acc;
      sh_it  = sh << 1;
      mq_it  = mq >> 1;
    end
    mul_fin = neg_res ? (~acc_it + W2'(1)) : acc_it;
    q_fin   = neg_res ? (~mq_it + W'(1)) : mq_it;
    r_fin   = neg_rem ? (~acc_it[W-1:0] + W'(1)) : acc_it[W-1:0];
    hi_fin  = is_div ? r_fin : mul_fin[W2-1:W];
    lo_fin  = is_div ? q_fin : mul_fin[W-1:0];
    last    = (cnt == CNT_WIDTH'(W - 1));
`ifdef MULDIV_EARLY_EXIT_EN
    if (!is_div && (mq_it == '0)) begin
      last = 1'b1;
    end
`else
`endif
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (dbz) begin
          state_next = DONE;
        end else if (accept) begin
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (resp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath and registered handshake/response outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      req_ready   <= 1'b1;
      resp_valid  <= 1'b0;
      resp_hi     <= '0;
      resp_lo     <= '0;
      div_by_zero <= 1'b0;
      cnt         <= '0;
      is_div      <= 1'b0;
      neg_res     <= 1'b0;
      neg_rem     <= 1'b0;
      acc         <= '0;
      sh          <= '0;
      mq          <= '0;
    end else begin
      req_ready  <= (state_next == IDLE);
      resp_valid <= (state_next == DONE);
      case (state)
        IDLE: begin
          if (accept) begin
            cnt     <= '0;
            is_div  <= req_op[1];
            neg_res <= a_neg ^ b_neg;
            neg_rem <= a_neg;
            acc     <= '0;
            if (req_op[1]) begin
              sh <= {{W{1'b0}}, b_mag};
              mq <= a_mag;
            end else begin
              sh <= {{W{1'b0}}, a_mag};
              mq <= b_mag;
            end
          end
          if (dbz) begin
            resp_hi     <= A;
            resp_lo     <= '1;
            div_by_zero <= 1'b1;
          end
        end
        BUSY: begin
          acc <= acc_it;
          sh  <= sh_it;
          mq  <= mq_it;
          cnt <= cnt + CNT_WIDTH'(1);
          if (last) begin
            resp_hi <= hi_fin;
            resp_lo <= lo_fin;
          end
        end
        DONE: begin
          if (resp_ready) begin
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
